// File: rtl/fifo_sync_core_pkg.sv
// -----------------------------------------------------------------------------
// fifo_sync_core_pkg
// Shared definitions for the synchronous FIFO slice.
//   `BIT_DEPTH   : stored word width (32)
//   `FIFO_ADDR_W : pointer width (4)
//   `FIFO_DEPTH  : derived number of words (2**`FIFO_ADDR_W)
// The macros carry the fifo_defs.vh content so that every file of the slice
// sees the same values; the package re-exports them as typed localparams.
// Optional feature macro used elsewhere in the slice: FIFO_ERR_STICKY_EN.
// -----------------------------------------------------------------------------
`ifndef FIFO_DEFS_VH
`define FIFO_DEFS_VH
`define BIT_DEPTH 32
`define FIFO_ADDR_W 4
`define FIFO_DEPTH (1 << `FIFO_ADDR_W)
`endif

package fifo_sync_core_pkg;

  localparam int FIFO_DATA_W_DEF = `BIT_DEPTH;
  localparam int FIFO_ADDR_W_DEF = `FIFO_ADDR_W;
  localparam int FIFO_DEPTH_DEF  = `FIFO_DEPTH;

endpackage

// File: rtl/fifo_dpram.sv
// -----------------------------------------------------------------------------
// fifo_dpram
// Simple dual-port RAM: one synchronous write port, one registered read port.
// No reset on the array or on the read register so it maps onto
// distributed/block RAM. Read-before-write when both ports hit one address.
// Ports:
//   clk      : clock
//   wr_en    : write enable
//   wr_addr  : write address
//   wr_data  : write data
//   rd_en    : read enable (read register holds when low)
//   rd_addr  : read address
//   rd_data  : registered read data
// -----------------------------------------------------------------------------
module fifo_dpram
  import fifo_sync_core_pkg::*;
#(
  parameter int DATA_W = FIFO_DATA_W_DEF,
  parameter int ADDR_W = FIFO_ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem_r [0:(1 << ADDR_W) - 1];

  // Storage array write and registered read (old data returned on collision).
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_r[wr_addr] <= wr_data;
    end
    if (rd_en) begin
      rd_data <= mem_r[rd_addr];
    end
  end

endmodule

// File: rtl/fifo_sync_core.sv
// -----------------------------------------------------------------------------
// fifo_sync_core
// Single-clock circular-buffer FIFO fed by one-cycle write/read strobes.
// Read data appears one cycle after an accepted read strobe.
// Ports:
//   clk       : system clock, rising edge
//   rst       : asynchronous active-high reset
//   wr_en     : write strobe
//   wr_data   : word to store while wr_en=1
//   rd_en     : read strobe
//   rd_data   : last word read (0 after reset)
//   rd_valid  : one-cycle pulse, rd_data updated
//   full      : count == 2**ADDR_W
//   empty     : count == 0
//   count     : occupancy 0..2**ADDR_W
//   wr_ack    : one-cycle pulse, preceding write accepted
// Optional (macro FIFO_ERR_STICKY_EN):
//   err_clr   : clears sticky error flags (a new error in the same cycle wins)
//   overflow  : sticky, set by a rejected write
//   underflow : sticky, set by a rejected read
// -----------------------------------------------------------------------------
module fifo_sync_core
  import fifo_sync_core_pkg::*;
#(
  parameter int DATA_W = FIFO_DATA_W_DEF,
  parameter int ADDR_W = FIFO_ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              full,
  output logic              empty,
  output logic [ADDR_W:0]   count,
  output logic              wr_ack
`ifdef FIFO_ERR_STICKY_EN
  ,
  input  logic              err_clr,
  output logic              overflow,
  output logic              underflow
`endif
);

  localparam logic [ADDR_W-1:0] PTR_ONE   = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [ADDR_W:0]   CNT_ONE   = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [ADDR_W:0]   CNT_ZERO  = {(ADDR_W+1){1'b0}};
  localparam logic [ADDR_W:0]   CNT_DEPTH = {1'b1, {ADDR_W{1'b0}}};

  logic [ADDR_W-1:0] wr_ptr_r;
  logic [ADDR_W-1:0] rd_ptr_r;
  logic [ADDR_W:0]   count_r;
  logic [ADDR_W:0]   count_nxt_s;
  logic              full_r;
  logic              empty_r;
  logic              rd_valid_r;
  logic              wr_ack_r;
  logic              rd_seen_r;
  logic              wr_acc_s;
  logic              rd_acc_s;
  logic [DATA_W-1:0] ram_q_s;

  // Acceptance: a read frees a slot in the same cycle, so a full FIFO still
  // takes a write alongside a read.
  always_comb begin
    rd_acc_s = rd_en & ~empty_r;
    wr_acc_s = wr_en & (~full_r | rd_acc_s);
  end

  // Next occupancy, shared by the count register and the flag registers.
  always_comb begin
    count_nxt_s = count_r;
    if (wr_acc_s && !rd_acc_s) begin
      count_nxt_s = count_r + CNT_ONE;
    end else if (rd_acc_s && !wr_acc_s) begin
      count_nxt_s = count_r - CNT_ONE;
    end else begin
      count_nxt_s = count_r;
    end
  end

  // Pointers, occupancy, flags and strobe acknowledgements.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_r   <= {ADDR_W{1'b0}};
      rd_ptr_r   <= {ADDR_W{1'b0}};
      count_r    <= CNT_ZERO;
      full_r     <= 1'b0;
      empty_r    <= 1'b1;
      rd_valid_r <= 1'b0;
      wr_ack_r   <= 1'b0;
      rd_seen_r  <= 1'b0;
    end else begin
      if (wr_acc_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (rd_acc_s) begin
        rd_ptr_r  <= rd_ptr_r + PTR_ONE;
        rd_seen_r <= 1'b1;
      end
      count_r    <= count_nxt_s;
      full_r     <= (count_nxt_s == CNT_DEPTH);
      empty_r    <= (count_nxt_s == CNT_ZERO);
      rd_valid_r <= rd_acc_s;
      wr_ack_r   <= wr_acc_s;
    end
  end

  fifo_dpram #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk     (clk),
    .wr_en   (wr_acc_s),
    .wr_addr (wr_ptr_r),
    .wr_data (wr_data),
    .rd_en   (rd_acc_s),
    .rd_addr (rd_ptr_r),
    .rd_data (ram_q_s)
  );

  // The RAM read register has no reset; until a read has completed since
  // reset the output shows zero instead of stale RAM contents.
  assign rd_data  = rd_seen_r ? ram_q_s : {DATA_W{1'b0}};
  assign rd_valid = rd_valid_r;
  assign full     = full_r;
  assign empty    = empty_r;
  assign count    = count_r;
  assign wr_ack   = wr_ack_r;

`ifdef FIFO_ERR_STICKY_EN
  logic overflow_r;
  logic underflow_r;

  // Sticky error flags; a fresh error takes priority over err_clr.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow_r  <= 1'b0;
      underflow_r <= 1'b0;
    end else begin
      if (wr_en && !wr_acc_s) begin
        overflow_r <= 1'b1;
      end else if (err_clr) begin
        overflow_r <= 1'b0;
      end
      if (rd_en && empty_r) begin
        underflow_r <= 1'b1;
      end else if (err_clr) begin
        underflow_r <= 1'b0;
      end
    end
  end

  assign overflow  = overflow_r;
  assign underflow = underflow_r;
`endif

endmodule
